// File: rtl/core_pkg.sv
// Shared types and constants for the rv32e core front end.
package core_pkg;

  typedef enum logic [1:0] {
    StRequest,
    StWait,
    StHold
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_packet_t;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one read at a time on a req/rsp bus and
// presents each fetched instruction with its PC on a valid/ready output.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          discard_q, discard_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          out_valid_q, out_valid_d;
  fetch_packet_t pkt_q, pkt_d;
  logic          req_fire;

  assign req_fire = req_valid_q && req_ready;

  // Next-state logic; a redirect overrides the normal flow in every state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    out_valid_d = out_valid_q;
    pkt_d       = pkt_q;

    unique case (state_q)
      StRequest: begin
        if (redirect_valid) begin
          pc_d = align_pc(redirect_pc);
          // An address accepted this cycle is stale; its response must be thrown away.
          if (req_fire) begin
            state_d   = StWait;
            discard_d = 1'b1;
          end
        end else if (req_fire) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (redirect_valid) begin
          pc_d = align_pc(redirect_pc);
          if (rsp_valid) begin
            // The only outstanding response arrived and is dropped: nothing left in flight.
            discard_d = 1'b0;
            state_d   = StRequest;
          end else begin
            discard_d = 1'b1;
          end
        end else if (rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StRequest;
          end else begin
            pkt_d       = '{pc: pc_q, instr: (rsp_error ? NOP_INSTR : rsp_data), fault: rsp_error};
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = StHold;
          end
        end
      end

      StHold: begin
        if (redirect_valid) begin
          pc_d        = align_pc(redirect_pc);
          out_valid_d = 1'b0;
          state_d     = StRequest;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StRequest;
        end
      end

      default: begin
        state_d     = StRequest;
        out_valid_d = 1'b0;
        discard_d   = 1'b0;
      end
    endcase

    // Registered request outputs track the state and PC we are about to enter.
    req_valid_d = (state_d == StRequest);
    req_addr_d  = pc_d;
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRequest;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      out_valid_q <= 1'b0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      out_valid_q <= out_valid_d;
      pkt_q       <= pkt_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign out_valid = out_valid_q;
  assign out_instr = pkt_q.instr;
  assign out_pc    = pkt_q.pc;
  assign out_fault = pkt_q.fault;

`ifndef SYNTHESIS
  // A response may only arrive while a read is outstanding.
  rsp_only_in_wait: assert property (@(posedge clock) disable iff (reset)
    rsp_valid |-> (state_q == StWait));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_data;
  logic        out_valid, out_ready, out_fault;
  logic [31:0] out_instr, out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_stage #(
    .RESET_PC (ResetPc),
    .NOP_INSTR(Nop)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_error     (rsp_error),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_fault     (out_fault),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;
  int n_out   = 0;
  int n_err   = 0;
  int n_redir = 0;

  // Reference model: next fetch address, the expected held packet, and the one bus read.
  logic [31:0] m_pc;
  logic        m_pkt_valid;
  logic [31:0] m_pkt_pc, m_pkt_instr;
  logic        m_pkt_fault;
  logic        q_busy, q_stale, q_err;
  logic [31:0] q_addr, q_data;
  int unsigned q_cnt;

  // Stimulus knobs (percentages / max response delay).
  int unsigned p_ready, p_out_ready, p_redir, p_err, max_delay;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc        = ResetPc;
    m_pkt_valid = 1'b0;
    m_pkt_pc    = '0;
    m_pkt_instr = '0;
    m_pkt_fault = 1'b0;
    q_busy      = 1'b0;
    q_stale     = 1'b0;
    q_err       = 1'b0;
    q_addr      = '0;
    q_data      = '0;
    q_cnt       = 0;
  endtask

  task automatic idle_inputs();
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    rsp_error      = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic check_reset_values();
    check_eq("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check_eq("rst_req_addr", req_addr, ResetPc);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_fault", {31'b0, out_fault}, 32'd0);
  endtask

  // One clock cycle: check outputs against the model, drive new inputs, advance the model
  // by the events that the coming rising edge will commit.
  task automatic step();
    logic        rsp, redir, rfire, ofire;
    logic [31:0] rpc;
    @(negedge clock);

    // Fetch issues a request exactly when nothing is in flight and nothing is held.
    check_eq("req_valid", {31'b0, req_valid}, {31'b0, (!q_busy && !m_pkt_valid)});
    if (req_valid) check_eq("req_addr", req_addr, m_pc);
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, m_pkt_valid});
    if (m_pkt_valid) begin
      check_eq("out_pc", out_pc, m_pkt_pc);
      check_eq("out_instr", out_instr, m_pkt_instr);
      check_eq("out_fault", {31'b0, out_fault}, {31'b0, m_pkt_fault});
    end

    rsp = 1'b0;
    if (q_busy) begin
      if (q_cnt == 0) rsp = 1'b1;
      else q_cnt--;
    end
    rsp_valid = rsp;
    rsp_data  = rsp ? q_data : $urandom;
    rsp_error = rsp ? q_err : 1'b0;
    req_ready = ($urandom_range(0, 99) < p_ready);
    out_ready = ($urandom_range(0, 99) < p_out_ready);
    redir     = ($urandom_range(0, 99) < p_redir);
    case ($urandom_range(0, 3))
      0:       rpc = 32'h0000_0103;
      1:       rpc = 32'hFFFF_FFFF;
      default: rpc = $urandom;
    endcase
    redirect_valid = redir;
    redirect_pc    = redir ? rpc : $urandom;

    rfire = req_valid && req_ready;
    ofire = out_valid && out_ready;

    if (rsp) begin
      q_busy = 1'b0;
      if (!q_stale && !redir) begin
        m_pkt_valid = 1'b1;
        m_pkt_pc    = q_addr;
        m_pkt_instr = q_err ? Nop : q_data;
        m_pkt_fault = q_err;
        m_pc        = q_addr + 32'd4;
        if (q_err) n_err++;
      end
    end
    if (ofire && !redir) begin
      m_pkt_valid = 1'b0;
      n_out++;
    end
    if (rfire) begin
      q_busy  = 1'b1;
      q_stale = 1'b0;
      q_addr  = m_pc;
      q_data  = $urandom;
      q_err   = ($urandom_range(0, 99) < p_err);
      q_cnt   = $urandom_range(0, max_delay);
    end
    if (redir) begin
      n_redir++;
      m_pc        = rpc & ~32'd3;
      m_pkt_valid = 1'b0;
      if (q_busy) q_stale = 1'b1;
    end
  endtask

  initial begin
    int guard;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values();
    reset = 1'b0;

    // Streaming bus with single-cycle responses and an always-ready consumer.
    p_ready = 100; p_out_ready = 100; p_redir = 0; p_err = 0; max_delay = 0;
    repeat (15) step();
    check_eq("stream_progress", (n_out >= 3) ? 32'd1 : 32'd0, 32'd1);

    // Fully random traffic: stalls, long holds, redirects in every state, bus errors.
    p_ready = 60; p_out_ready = 50; p_redir = 8; p_err = 15; max_delay = 3;
    repeat (3000) step();
    check_eq("random_progress", (n_out > 100) ? 32'd1 : 32'd0, 32'd1);
    check_eq("saw_errors", (n_err > 0) ? 32'd1 : 32'd0, 32'd1);

    // Asynchronous reset while a read is in flight.
    p_redir = 0; max_delay = 3;
    guard = 0;
    while (!q_busy && guard < 200) begin
      step();
      guard++;
    end
    check_eq("found_wait", {31'b0, q_busy}, 32'd1);
    #1;
    idle_inputs();
    reset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    p_ready = 70; p_out_ready = 70; p_redir = 5; p_err = 10; max_delay = 2;
    repeat (400) step();
    check_eq("post_reset_progress", (n_out > 120) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
